// File: rtl/flash_loader_pkg.sv
// Shared types and constants for the boot-time SPI flash loader.
package flash_loader_pkg;

  localparam logic [7:0] SPI_READ = 8'h03;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    DATA,
    END,
    HOLD
  } state_t;

endpackage

// File: rtl/spi_shift.sv
// Mode-0 SPI shifter: ck generation, 32-bit tx shift, 8-bit rx capture.
module spi_shift (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] tx,
  input  logic        miso,
  output logic        ck,
  output logic        mosi,
  output logic [7:0]  rx,
  output logic        fall
);

  logic [31:0] sr;

  assign mosi = sr[31];
  // High on the ce that produces a falling edge, i.e. a completed bit.
  assign fall = step && ck;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sr <= '0;
      ck <= 1'b0;
      rx <= '0;
    end else if (load) begin
      sr <= tx;
      ck <= 1'b0;
    end else if (step) begin
      if (!ck) begin
        ck <= 1'b1;
        rx <= {rx[6:0], miso};
      end else begin
        ck <= 1'b0;
        sr <= {sr[30:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/flash_loader.sv
// Boot loader: issues one READ to SPI flash and streams the image to SRAM.
module flash_loader
  import flash_loader_pkg::*;
#(
  parameter logic [23:0] ADDR = 24'h000000,
  parameter int          LEN  = 65537,
  parameter int          AW   = 19
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ce,
  output logic          cs,
  output logic          ck,
  output logic          mosi,
  input  logic          miso,
  output logic          memWe,
  output logic [AW-1:0] memA,
  output logic [7:0]    memD,
  output logic          vga,
  output logic          cfgOk,
  output logic          done
);

  localparam int BW = $clog2(LEN + 1);

  state_t        state;
  logic [4:0]    bits;
  logic [BW-1:0] bytes;
  logic          load;
  logic          step;
  logic          fall;
  logic [7:0]    rx;

  assign load = ce && (state == IDLE);
  assign step = ce && ((state == CMD) || (state == DATA));

  spi_shift u_spi (
    .clock (clock),
    .reset (reset),
    .load  (load),
    .step  (step),
    .tx    ({SPI_READ, ADDR}),
    .miso  (miso),
    .ck    (ck),
    .mosi  (mosi),
    .rx    (rx),
    .fall  (fall)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cs    <= 1'b1;
      bits  <= '0;
      bytes <= '0;
      memWe <= 1'b0;
      memA  <= '0;
      memD  <= '0;
      vga   <= 1'b0;
      cfgOk <= 1'b0;
      done  <= 1'b0;
    end else begin
      memWe <= 1'b0;
      unique case (state)
        IDLE: begin
          if (ce) begin
            cs    <= 1'b0;
            bits  <= '0;
            state <= CMD;
          end
        end
        CMD: begin
          if (fall) begin
            bits <= bits + 5'd1;
            if (bits == 5'd31) begin
              bytes <= '0;
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (fall) begin
            bits <= bits + 5'd1;
            if (bits[2:0] == 3'd7) begin
              bytes <= bytes + 1'b1;
              // Byte 0 is the config byte and never reaches SRAM.
              if (bytes == '0) begin
                vga   <= rx[0];
                cfgOk <= 1'b1;
              end else begin
                memWe <= 1'b1;
                memD  <= rx;
                memA  <= AW'(bytes - 1'b1);
              end
              if (bytes == BW'(LEN - 1))
                state <= END;
            end
          end
        end
        END: begin
          if (ce) begin
            cs    <= 1'b1;
            done  <= 1'b1;
            state <= HOLD;
          end
        end
        HOLD: ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
